// File: rtl/aes_pkg.sv
// Shared AES-128 datapath types and byte-level helpers for the round pipeline.
package aes_pkg;

   localparam int unsigned AES_NB = 4;

   typedef logic [7:0]   byte_t;
   typedef logic [127:0] state_t;

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gmul3(input byte_t b);
      return xtime(b) ^ b;
   endfunction

   // Byte k lives at [127-8k -: 8]; row r of column c is byte 4c+r.
   function automatic state_t shift_rows(input state_t s);
      state_t res;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            res[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/shift_mix_stage_mix_column.sv
// Combinational AES MixColumns for a single 32-bit column (row 0 in the top byte).
module mix_column
   import aes_pkg::*;
(
   input  logic [31:0] col,
   output logic [31:0] mix
);

   byte_t s0, s1, s2, s3;

   assign s0 = col[31:24];
   assign s1 = col[23:16];
   assign s2 = col[15:8];
   assign s3 = col[7:0];

   assign mix = {xtime(s0) ^ gmul3(s1) ^ s2 ^ s3,
                 s0 ^ xtime(s1) ^ gmul3(s2) ^ s3,
                 s0 ^ s1 ^ xtime(s2) ^ gmul3(s3),
                 gmul3(s0) ^ s1 ^ s2 ^ xtime(s3)};

endmodule

// File: rtl/shift_mix_stage.sv
// ShiftRows + MixColumns round stage with valid/ready pipeline registers (1 or 2 deep).
module shift_mix_stage
   import aes_pkg::*;
#(
   parameter int unsigned NWords = 4,
   parameter int unsigned STAGES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [32*NWords-1:0]  in_state,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [32*NWords-1:0]  out_state,
   output logic                  out_last
);

   localparam int unsigned W = 32 * NWords;

   if (NWords != AES_NB) begin : g_bad_nwords
      $error("shift_mix_stage: NWords must be 4 for AES-128");
   end
   if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
      $error("shift_mix_stage: STAGES must be 1 or 2");
   end

   logic [W-1:0] sr_state;
   logic [W-1:0] mix_src;
   logic [W-1:0] mixed;
   logic [W-1:0] result;
   logic         mix_last;
   logic         src_valid;
   logic         out_stage_ready;

   logic         out_valid_q;
   logic [W-1:0] out_state_q;
   logic         out_last_q;

   assign sr_state = shift_rows(in_state);

   for (genvar c = 0; c < NWords; c++) begin : g_col
      mix_column u_mix_column (
         .col (mix_src[W-1-32*c -: 32]),
         .mix (mixed[W-1-32*c -: 32])
      );
   end

   // Final round skips MixColumns; ShiftRows has already been applied to mix_src.
   assign result = mix_last ? mix_src : mixed;

   assign out_stage_ready = !out_valid_q || out_ready;

   if (STAGES == 1) begin : g_one_stage
      assign src_valid = in_valid;
      assign mix_src   = sr_state;
      assign mix_last  = in_last;
      assign in_ready  = out_stage_ready;
   end else begin : g_two_stage
      logic         s1_valid_q;
      logic [W-1:0] s1_state_q;
      logic         s1_last_q;
      logic         s1_ready;

      assign s1_ready = !s1_valid_q || out_stage_ready;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_state_q <= '0;
            s1_last_q  <= 1'b0;
         end else if (s1_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_state_q <= sr_state;
               s1_last_q  <= in_last;
            end
         end
      end

      assign src_valid = s1_valid_q;
      assign mix_src   = s1_state_q;
      assign mix_last  = s1_last_q;
      assign in_ready  = s1_ready;
   end

   // Data is only captured on a transfer, so it holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_state_q <= '0;
         out_last_q  <= 1'b0;
      end else if (out_stage_ready) begin
         out_valid_q <= src_valid;
         if (src_valid) begin
            out_state_q <= result;
            out_last_q  <= mix_last;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_state = out_state_q;
   assign out_last  = out_last_q;

endmodule
